// File: rtl/evr_rx_link_ctrl_if.sv
// ============================================================================
// Module      : evr_rx_link_ctrl_if
// Description : GTX channel / bit-slide aligner signal bundle for the EVR
//               receive-link bring-up sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface evr_rx_link_ctrl_if;
    logic       enable_i;
    logic       cplllock_i;
    logic       rxresetdone_i;
    logic       synced_i;
    logic [4:0] bitslide_i;
    logic       gtrxreset_o;
    logic       link_up_o;
    logic       fail_o;
    logic [9:0] retry_cnt_o;
    logic [2:0] state_o;

    modport slave (
        input  enable_i, cplllock_i, rxresetdone_i, synced_i, bitslide_i,
        output gtrxreset_o, link_up_o, fail_o, retry_cnt_o, state_o
    );

    modport master (
        output enable_i, cplllock_i, rxresetdone_i, synced_i, bitslide_i,
        input  gtrxreset_o, link_up_o, fail_o, retry_cnt_o, state_o
    );
endinterface

`default_nettype wire

// File: rtl/evr_rx_link_ctrl.sv
// ============================================================================
// Module      : evr_rx_link_ctrl
// Description : EVR GTX receive-link bring-up sequencer; re-resets the channel
//               until the aligner reports the target bit-slide count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module evr_rx_link_ctrl #(
    parameter logic [4:0]  TARGET_SLIDE     = 5'd2,
    parameter int unsigned RST_PULSE_CYCLES = 16,
    parameter int unsigned STEP_TIMEOUT     = 1_000_000,
    parameter int unsigned MAX_RETRIES      = 1023
) (
    input  wire logic          rx_clk_i,
    input  wire logic          rst_i,
    evr_rx_link_ctrl_if.slave  link
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RESET     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_WAIT_SYNC = 3'd4,
        ST_CHECK     = 3'd5,
        ST_UP        = 3'd6,
        ST_FAIL      = 3'd7
    } state_t;

    localparam logic [23:0] C_RST_LOAD  = 24'(RST_PULSE_CYCLES - 1);
    localparam logic [23:0] C_STEP_LOAD = 24'(STEP_TIMEOUT - 1);
    localparam logic [9:0]  C_MAX_RETRY = 10'(MAX_RETRIES);

    logic        lock_meta_q, lock_sync_q;
    logic        done_meta_q, done_sync_q;
    state_t      state_q, state_d;
    logic [23:0] timer_q, timer_d;
    logic [9:0]  retry_q, retry_d;
    logic        gtrxreset_q, gtrxreset_d;
    logic        link_up_q, link_up_d;
    logic        fail_q, fail_d;
    logic        retry_ev;

    always_ff @(posedge rx_clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            done_meta_q <= 1'b0;
            done_sync_q <= 1'b0;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            retry_q     <= '0;
            gtrxreset_q <= 1'b1;
            link_up_q   <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            lock_meta_q <= link.cplllock_i;
            lock_sync_q <= lock_meta_q;
            done_meta_q <= link.rxresetdone_i;
            done_sync_q <= done_meta_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            gtrxreset_q <= gtrxreset_d;
            link_up_q   <= link_up_d;
            fail_q      <= fail_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        retry_d  = retry_q;
        retry_ev = 1'b0;

        if (!link.enable_i) begin
            state_d = ST_IDLE;
            timer_d = '0;
            retry_d = '0;
        end else if (!lock_sync_q && (state_q inside {ST_RESET, ST_WAIT_DONE,
                                                      ST_WAIT_SYNC, ST_CHECK, ST_UP})) begin
            // Lock loss overrides any coincident retry event and leaves the count alone.
            state_d = ST_WAIT_LOCK;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                    retry_d = '0;
                end
                ST_WAIT_LOCK: begin
                    if (lock_sync_q) begin
                        state_d = ST_RESET;
                        timer_d = C_RST_LOAD;
                    end
                end
                ST_RESET: begin
                    if (timer_q == '0) begin
                        state_d = ST_WAIT_DONE;
                        timer_d = C_STEP_LOAD;
                    end else begin
                        timer_d = timer_q - 24'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (done_sync_q) begin
                        state_d = ST_WAIT_SYNC;
                        timer_d = C_STEP_LOAD;
                    end else if (timer_q == '0) begin
                        retry_ev = 1'b1;
                    end else begin
                        timer_d = timer_q - 24'd1;
                    end
                end
                ST_WAIT_SYNC: begin
                    if (link.synced_i) begin
                        state_d = ST_CHECK;
                    end else if (timer_q == '0) begin
                        retry_ev = 1'b1;
                    end else begin
                        timer_d = timer_q - 24'd1;
                    end
                end
                ST_CHECK: begin
                    if (link.synced_i && (link.bitslide_i == TARGET_SLIDE)) begin
                        state_d = ST_UP;
                        retry_d = '0;
                    end else begin
                        retry_ev = 1'b1;
                    end
                end
                ST_UP: begin
                    if (!link.synced_i) begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (retry_ev) begin
                if (retry_q == C_MAX_RETRY) begin
                    state_d = ST_FAIL;
                end else begin
                    retry_d = retry_q + 10'd1;
                    state_d = ST_RESET;
                    timer_d = C_RST_LOAD;
                end
            end
        end
    end

    // Outputs decode the next state so the registered copies line up with state_q.
    always_comb begin
        gtrxreset_d = (state_d inside {ST_IDLE, ST_WAIT_LOCK, ST_RESET, ST_FAIL});
        link_up_d   = (state_d == ST_UP);
        fail_d      = (state_d == ST_FAIL);
    end

    assign link.gtrxreset_o = gtrxreset_q;
    assign link.link_up_o   = link_up_q;
    assign link.fail_o      = fail_q;
    assign link.retry_cnt_o = retry_q;
    assign link.state_o     = state_q;

endmodule

`default_nettype wire

// File: doc/evr_rx_link_ctrl.md
# evr_rx_link_ctrl

Receive-link bring-up sequencer for the EVR GTX receiver. It sits between the GTX channel and the comma bit-slide aligner, both clocked by the recovered user clock. It waits for CPLL lock and pulses the GTX RX reset, then waits for reset-done and comma alignment. It re-resets the channel until the aligner reports the required bit-slide count, which fixes the recovered-clock phase, with bounded timeouts, a retry limit and link-loss recovery.

## Interface
Parameters:
- TARGET_SLIDE, 5'd2: bit-slide count that gives the required recovered-clock phase.
- RST_PULSE_CYCLES, 16: `gtrxreset_o` pulse length in cycles; must be ≥1.
- STEP_TIMEOUT, 1_000_000: maximum cycles spent in WAIT_DONE, and separately in WAIT_SYNC; must be < 2^24.
- MAX_RETRIES, 1023: failed attempts allowed before FAIL; must be ≤1023.

Ports:
- rx_clk_i  in  1  recovered user clock; the only clock.
- rst_i  in  1  reset, asynchronous, active-high.
- enable_i  in  1  run request, synchronous to rx_clk_i.
- cplllock_i  in  1  GTX CPLL lock; asynchronous, double-flopped internally.
- rxresetdone_i  in  1  GTX RX reset done; asynchronous, double-flopped internally.
- synced_i  in  1  aligner synced, rx_clk_i domain.
- bitslide_i  in  5  aligner bit-slide count, rx_clk_i domain; valid while synced_i=1.
- gtrxreset_o  out  1  GTX RX reset request.
- link_up_o  out  1  link aligned at TARGET_SLIDE.
- fail_o  out  1  retry limit exhausted.
- retry_cnt_o  out  10  failed attempts since the last UP or IDLE.
- state_o  out  3  current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, WAIT_LOCK=1, RESET=2, WAIT_DONE=3, WAIT_SYNC=4, CHECK=5, UP=6, FAIL=7.
- Transition priority: `rst_i` first, then `enable_i`=0 (go to IDLE from any state), then loss of synchronized lock, then the per-state rule.
- IDLE: clears `retry_cnt_o` and the timer. Moves to WAIT_LOCK when `enable_i`=1.
- WAIT_LOCK: moves to RESET on synchronized lock=1. There is no timeout here.
- RESET: loads the timer with RST_PULSE_CYCLES−1 and counts down. At 0, moves to WAIT_DONE and loads the timer with STEP_TIMEOUT−1.
- WAIT_DONE: synchronized reset-done=1 moves to WAIT_SYNC and reloads the timer. Timer reaching 0 is a retry event.
- WAIT_SYNC: `synced_i`=1 moves to CHECK. Timer reaching 0 is a retry event.
- CHECK: lasts one cycle.
  - `bitslide_i`==TARGET_SLIDE and `synced_i`=1: go to UP and clear `retry_cnt_o`.
  - Otherwise: retry event.
- Retry event:
  - If `retry_cnt_o`==MAX_RETRIES, go to FAIL.
  - Otherwise increment `retry_cnt_o` and go to RESET.
  - `retry_cnt_o` never wraps.
- UP: `synced_i`=0 or lock loss moves to WAIT_LOCK. Neither counts as a retry.
- Lock loss in RESET, WAIT_DONE, WAIT_SYNC, CHECK or UP moves to WAIT_LOCK. `retry_cnt_o` is unchanged.
- FAIL: held until `enable_i`=0 or `rst_i`. Lock changes are ignored in FAIL.
- Output decode, per state:
  - `gtrxreset_o`=1 in IDLE, WAIT_LOCK, RESET and FAIL; 0 otherwise.
  - `link_up_o`=1 only in UP.
  - `fail_o`=1 only in FAIL.
- Arithmetic: the timer is a 24-bit down-counter; `retry_cnt_o` is 10 bits unsigned, saturating at MAX_RETRIES.

## Timing
- Reset values: state=IDLE, `gtrxreset_o`=1, `link_up_o`=0, `fail_o`=0, `retry_cnt_o`=0, `state_o`=0, timer=0, synchronizers=0.
- All outputs are registered. Each output is a pure function of the state register or the counter, with no input-to-output combinational path.
- Asynchronous inputs (`cplllock_i`, `rxresetdone_i`) pass through a 2-flop synchronizer. An edge is seen by the FSM 2 cycles later, and the FSM acts on the following edge.
- `gtrxreset_o` high time in RESET is exactly RST_PULSE_CYCLES cycles.
- WAIT_DONE and WAIT_SYNC each time out after exactly STEP_TIMEOUT cycles in that state.
- UP is entered exactly one cycle after entering CHECK.
- `rst_i` asserted mid-sequence forces reset values immediately. Sequencing restarts from IDLE on the first edge after release.
- Simultaneous retry event and lock loss: lock loss wins. The state goes to WAIT_LOCK and `retry_cnt_o` is unchanged.

## Test plan
Bench parameters: RST_PULSE_CYCLES=4, STEP_TIMEOUT=100, MAX_RETRIES=3, TARGET_SLIDE=2.
- Clean bring-up: enable=1, lock=1, resetdone rises 10 cycles after `gtrxreset_o` falls, synced=1 with bitslide=2. Required: `gtrxreset_o` high for exactly 4 cycles in RESET, then `link_up_o`=1 and `retry_cnt_o`=0.
- Wrong phase: bitslide=5 on the first two attempts and 2 on the third. Required: three `gtrxreset_o` pulses, `retry_cnt_o` reaching 2, then cleared to 0 on entering UP.
- Exhaustion: bitslide is always 7. Required: after 4 failed CHECKs, `fail_o`=1, `gtrxreset_o`=1 and `retry_cnt_o`=3. Then enable=0 gives IDLE with `fail_o`=0 and `retry_cnt_o`=0.
- Timeout: resetdone is never asserted. Required: a retry event exactly 100 cycles after entering WAIT_DONE, `state_o` returns to 2, and `retry_cnt_o` increments.
- Link loss: in UP, drop lock. Required: `link_up_o`=0 and state WAIT_LOCK within 3 cycles, `retry_cnt_o` unchanged. Restoring lock relocks through RESET.
- Async reset mid-WAIT_SYNC: assert rst_i between clock edges. Required: outputs take reset values without waiting for a clock edge, and sequencing restarts from IDLE after release.
